cosine_job_sched: RTL and testbench

- Shares one cosine_sim engine between N_REQ requesters.
- Arbitrates round-robin among pending jobs and latches the winner's vectors into holding registers, so the engine sees stable inputs for the whole computation.
- Pulses the engine start and waits for engine valid, guarded by a watchdog.
- Returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the accelerator's register/DMA front-end and the cosine_sim instance.

---
 rtl/cosine_job_sched.sv | 155 +++++++++++++++
 tb/tb_cosine_job_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosine_job_sched.sv
// Round-robin job scheduler that time-shares one cosine_sim engine among N_REQ requesters.
// Latches the winner's vectors, runs the engine under a watchdog, returns a tagged response.
module cosine_job_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*W*32-1:0]  req_vec_a,
  input  logic [N_REQ*W*32-1:0]  req_vec_b,
  output logic                   eng_start,
  output logic [W*32-1:0]        eng_vec_a,
  output logic [W*32-1:0]        eng_vec_b,
  input  logic [31:0]            eng_similarity,
  input  logic                   eng_valid,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [15:0]            jobs_done
);

  localparam int unsigned WdW     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NanWord = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [W*32-1:0]    vec_a_q, vec_a_d;
  logic [W*32-1:0]    vec_b_q, vec_b_d;
  logic [WdW-1:0]     wdog_q, wdog_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [15:0]        jobs_q, jobs_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;

  // Rotating priority search: first pending requester at or above rr_q, wrapping.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_t;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_t       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx   = (32'(rr_q) + k) % N_REQ;
      idx_t = IDW'(idx);
      if (!grant_found && req_valid[idx_t]) begin
        grant_found = 1'b1;
        grant_id    = idx_t;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    vec_a_d   = vec_a_q;
    vec_b_d   = vec_b_q;
    wdog_d    = wdog_q;
    data_d    = data_q;
    err_d     = err_q;
    jobs_d    = jobs_q;
    req_ready = '0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no accept strobe is shown while reset is held.
        if (grant_found && rst_n) begin
          req_ready[grant_id] = 1'b1;
          vec_a_d = req_vec_a[32'(grant_id) * (W * 32) +: W * 32];
          vec_b_d = req_vec_b[32'(grant_id) * (W * 32) +: W * 32];
          id_d    = grant_id;
          state_d = StStart;
        end
      end
      StStart: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        // A result arriving on the last watchdog cycle still counts as success.
        if (eng_valid) begin
          data_d  = eng_similarity;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          data_d  = NanWord;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_d    = (32'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
          jobs_d  = jobs_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      vec_a_q <= '0;
      vec_b_q <= '0;
      wdog_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  assign eng_start = (state_q == StStart);
  assign eng_vec_a = vec_a_q;
  assign eng_vec_b = vec_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != StIdle);
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_cosine_job_sched.sv
// Bench for cosine_job_sched: random and directed jobs, an engine model, and a scoreboard
// whose expectations come from a requester-level model of the round-robin rules.
module tb_cosine_job_sched;
  localparam int N   = 4;
  localparam int W   = 5;
  localparam int TO  = 64;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*W*32-1:0]    req_vec_a = '0;
  logic [N*W*32-1:0]    req_vec_b = '0;
  logic                 eng_start;
  logic [W*32-1:0]      eng_vec_a;
  logic [W*32-1:0]      eng_vec_b;
  logic [31:0]          eng_similarity = '0;
  logic                 eng_valid = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [15:0]          jobs_done;

  cosine_job_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_a(req_vec_a), .req_vec_b(req_vec_b),
    .eng_start(eng_start), .eng_vec_a(eng_vec_a), .eng_vec_b(eng_vec_b),
    .eng_similarity(eng_similarity), .eng_valid(eng_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          err;
    int          eff;
  } exp_t;

  exp_t   sb[$];
  int     grant_log[$];
  int     nchk = 0, nerr = 0;
  longint cyc = 0;
  int     m_rr = 0, m_jobs = 0, n_start = 0;
  bit     m_busy = 0, chk_jobs = 0, prev_rv = 0;
  longint exp_start = -1, start_cyc = 0;
  int     eng_lat = 1, cur_lat = 1;
  bit     spur_req = 0, auto_drop = 1, rand_mode = 0;
  bit     granted[N];
  int     g_s;
  exp_t   e_s;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stand-in similarity: identical vectors give 1.0, otherwise a mixing hash.
  function automatic logic [31:0] sim_of(input logic [W*32-1:0] a, input logic [W*32-1:0] b);
    logic [31:0] acc;
    acc = 32'h1234_5678;
    if (a == b) return 32'h3F80_0000;
    for (int i = 0; i < W; i++) acc = {acc[30:0], acc[31]} ^ a[i*32 +: 32] ^ (b[i*32 +: 32] + 32'(i));
    return acc;
  endfunction

  function automatic int pick(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int r = 0; r < N; r++) if (v[r]) return r;
    return -1;
  endfunction

  // Engine model: answers cur_lat cycles after the start pulse (0 = never).
  initial begin
    int          cnt;
    logic [31:0] val;
    cnt = 0;
    val = '0;
    forever begin
      @(negedge clk);
      eng_valid = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng_valid      = 1'b1;
            eng_similarity = val;
          end
        end
        if (eng_start) begin
          cnt = cur_lat;
          val = sim_of(eng_vec_a, eng_vec_b);
        end
        if (spur_req) begin
          eng_valid      = 1'b1;
          eng_similarity = 32'hDEAD_BEEF;
          spur_req       = 0;
        end
      end
    end
  end

  // Scoreboard: predicts grants at issue time, checks responses when presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_busy = 0; m_rr = 0; m_jobs = 0; exp_start = -1; chk_jobs = 0; prev_rv = 0;
    end else begin
      if (chk_jobs) begin
        chk("jobs_done", 64'(jobs_done), 64'(m_jobs % 65536));
        chk_jobs = 0;
      end
      if (eng_start || cyc == exp_start) chk("eng_start", 64'(eng_start), 64'(cyc == exp_start));
      if (eng_start) begin
        start_cyc = cyc;
        n_start++;
      end
      if (!m_busy && req_valid != '0) begin
        g_s = pick(m_rr, req_valid);
        chk("req_ready_grant", 64'(req_ready), 64'(1) << g_s);
        grant_log.push_back(idx_of(req_ready));
        e_s.id   = g_s;
        e_s.err  = (eng_lat == 0);
        e_s.eff  = e_s.err ? TO : eng_lat;
        e_s.data = e_s.err ? 32'h7FC0_0000 :
                   sim_of(req_vec_a[g_s*W*32 +: W*32], req_vec_b[g_s*W*32 +: W*32]);
        sb.push_back(e_s);
        cur_lat   = eng_lat;
        exp_start = cyc + 1;
        m_busy    = 1;
        granted[g_s] = 1;
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'(0));
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding job, expected 0");
        end else begin
          e_s = sb[0];
          if (!prev_rv) chk("rsp_latency", 64'(cyc - start_cyc), 64'(e_s.eff + 1));
          chk("rsp_id", 64'(rsp_id), 64'(e_s.id));
          chk("rsp_data", 64'(rsp_data), 64'(e_s.data));
          chk("rsp_err", 64'(rsp_err), 64'(e_s.err));
          if (rsp_ready) begin
            void'(sb.pop_front());
            m_rr   = (e_s.id + 1) % N;
            m_busy = 0;
            m_jobs++;
            chk_jobs = 1;
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit same);
    logic [31:0] a, b;
    for (int i = 0; i < W; i++) begin
      a = $urandom;
      b = same ? a : $urandom;
      req_vec_a[(r*W+i)*32 +: 32] = a;
      req_vec_b[(r*W+i)*32 +: 32] = b;
    end
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_jobs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (m_jobs < target && n < budget) begin
      tick();
      n++;
    end
    if (m_jobs < target) begin
      nchk++; nerr++;
      $display("FAIL %s: timed out with %0d jobs done, expected %0d", name, m_jobs, target);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_eng_start"}, 64'(eng_start), 64'(0));
    chk({tag, "_eng_vec"}, 64'(|{eng_vec_a, eng_vec_b}), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_jobs_done"}, 64'(jobs_done), 64'(0));
  endtask

  // Requester behaviour: drop a request once accepted; in random mode also raise/withdraw.
  initial begin
    int x;
    forever begin
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (granted[r]) begin
          granted[r] = 0;
          if (auto_drop) req_valid[r] = 1'b0;
        end else if (rand_mode) begin
          if (!req_valid[r] && $urandom_range(0, 5) == 0) set_req(r, $urandom_range(0, 3) == 0);
          else if (req_valid[r] && $urandom_range(0, 19) == 0) req_valid[r] = 1'b0;
        end
      end
      if (rand_mode) begin
        rsp_ready = ($urandom_range(0, 2) != 0);
        x = $urandom_range(0, 15);
        eng_lat = (x == 0) ? 0 : (x == 1) ? TO : $urandom_range(1, 10);
      end
    end
  end

  initial begin
    logic [31:0] fl[5];
    int          exp_rr[5];
    int          n;
    fl[0] = 32'h3F80_0000; fl[1] = 32'h4000_0000; fl[2] = 32'h4040_0000;
    fl[3] = 32'h4080_0000; fl[4] = 32'h40A0_0000;
    exp_rr = '{0, 1, 2, 3, 0};

    tick(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick(2);

    // Single job from requester 2 with a == b == [1..5].
    eng_lat = 20;
    for (int i = 0; i < W; i++) begin
      req_vec_a[(2*W+i)*32 +: 32] = fl[i];
      req_vec_b[(2*W+i)*32 +: 32] = fl[i];
    end
    req_valid[2] = 1'b1;
    wait_jobs(1, 200, "single_job");
    tick(2);
    chk("single_start_pulses", 64'(n_start), 64'(1));
    chk("single_jobs_done", 64'(jobs_done), 64'(1));

    // Reset in the middle of a job that the engine never answers.
    eng_lat = 0;
    set_req(3, 0);
    tick(15);
    chk("wait_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midjob_reset");
    tick(2);
    req_valid = '0;
    rst_n = 1'b1;
    tick(2);
    eng_lat = 4;
    set_req(3, 0);
    wait_jobs(1, 100, "post_reset_job");
    tick(2);
    chk("post_reset_jobs_done", 64'(jobs_done), 64'(1));

    // Fairness with every requester continuously pending.
    grant_log.delete();
    auto_drop = 0;
    eng_lat = 2;
    for (int r = 0; r < N; r++) set_req(r, r % 2 == 1);
    n = 0;
    while (grant_log.size() < 5 && n < 400) begin
      tick();
      n++;
    end
    req_valid = '0;
    auto_drop = 1;
    wait_jobs(6, 100, "rr_jobs");
    chk("rr_grant_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(exp_rr[i]));

    // Watchdog timeout, then a normal job.
    eng_lat = 0;
    set_req(1, 0);
    wait_jobs(7, TO + 50, "timeout_job");
    eng_lat = 3;
    set_req(2, 0);
    wait_jobs(8, 100, "after_timeout_job");

    // Result on the last watchdog cycle, then a spurious strobe while idle.
    eng_lat = TO;
    set_req(0, 1);
    wait_jobs(9, TO + 50, "coincident_job");
    tick(2);
    spur_req = 1;
    tick(6);
    chk("spurious_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("spurious_busy", 64'(busy), 64'(0));
    chk("spurious_jobs_done", 64'(jobs_done), 64'(9));

    // Back-pressure with other requesters waiting.
    rsp_ready = 1'b0;
    eng_lat = 3;
    grant_log.delete();
    set_req(0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    set_req(1, 0);
    set_req(3, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    wait_jobs(12, 200, "bp_jobs");
    chk("bp_log_size", 64'(grant_log.size()), 64'(3));
    if (grant_log.size() >= 2) chk("bp_next_grant", 64'(grant_log[1]), 64'(1));

    // Randomised traffic.
    rand_mode = 1;
    wait_jobs(72, 20000, "random_jobs");
    rand_mode = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((m_busy || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (m_busy || sb.size() != 0) begin
      nchk++; nerr++;
      $display("FAIL drain: %0d jobs still outstanding, expected 0", sb.size());
    end
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
